vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: consumes the hsync/vsync/hblnk/vblnk

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_edge_det.sv | 39 +++
 rtl/vga_sync_decoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing definitions for the 800x600@60 mode.
// These constants are the default expected timing of vga_sync_decoder.
// The package also holds the decoder state and error-flag types and a
// saturating counter helper.
//
// Contents:
//   HOR_* / VER_*   expected line/frame timing (hcount/vcount positions)
//   CNT_W, CNT_MAX  recovered counter width and saturation value
//   IDX_*           bit positions of the four sync inputs in the edge vectors
//   sync_state_t    SEARCH / ACQUIRE / LOCKED
//   err_flags_t     sticky error flag layout ([0] h total .. [3] v sync)
//   sat_inc()       increment that sticks at CNT_MAX
// -----------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int HOR_SYNC_START  = 840;
  localparam int HOR_SYNC_STOP   = 968;

  // Vertical timing, in lines.
  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;
  localparam int VER_SYNC_START  = 601;
  localparam int VER_SYNC_STOP   = 605;

  // Consecutive clean frames needed before the decoder reports lock.
  localparam int LOCK_FRAMES_DEF = 2;

  // Recovered counters are 11 bits wide and never wrap.
  localparam int              CNT_W   = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Positions of the sync inputs inside the packed edge vectors.
  localparam int IDX_HSYNC = 0;
  localparam int IDX_VSYNC = 1;
  localparam int IDX_HBLNK = 2;
  localparam int IDX_VBLNK = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  // Packed MSB-first, so the field order gives bit [3] = v_sync ... [0] = h_total.
  typedef struct packed {
    logic v_sync;   // [3] vsync/vblnk edge misplaced
    logic v_total;  // [2] frame length wrong or vertical timeout
    logic h_sync;   // [1] hsync/hblnk edge misplaced
    logic h_total;  // [0] line length wrong or horizontal timeout
  } err_flags_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// -----------------------------------------------------------------------------
// vga_edge_det
// Two-flop sampler for one sync/blank input, with rise and fall detection.
// The input is registered into s1 and then into s2.
// An edge is reported while s1 and s2 differ.
// Edges therefore appear one cycle after the input is sampled.
//
// Ports:
//   clk   in  1  pixel clock
//   rst   in  1  synchronous active-high reset (clears both sample flops)
//   din   in  1  raw input level
//   rise  out 1  s1=1, s2=0
//   fall  out 1  s1=0, s2=1
// -----------------------------------------------------------------------------
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
    end
  end

  assign rise = s1_reg & ~s2_reg;
  assign fall = ~s1_reg & s2_reg;

endmodule

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing monitor.
// It recovers hcount/vcount from the hsync/vsync/hblnk/vblnk stream.
// It checks every line and frame against the expected timing.
// It reports lock state and sticky timing-violation flags.
//
// Anchors:
//   line anchor   hblnk falling edge; marks hcount = 0.
//   frame anchor  vblnk falling edge on a line anchor; marks vcount = 0.
//
// Latency: the outputs for the sample presented in cycle n appear in cycle n+2.
// All outputs are registered.
//
// Ports:
//   clk          in   1   pixel clock
//   rst          in   1   synchronous active-high reset
//   in_hsync     in   1   active-high hsync
//   in_vsync     in   1   active-high vsync (changes only at line start)
//   in_hblnk     in   1   horizontal blank
//   in_vblnk     in   1   vertical blank
//   clr_err      in   1   clear err_flags (a same-cycle new error wins)
//   locked       out  1   timing verified; hcount/vcount valid
//   hcount       out  11  recovered horizontal position (saturates at 2047)
//   vcount       out  11  recovered vertical position (saturates at 2047)
//   line_start   out  1   pulse with hcount == 0
//   frame_start  out  1   pulse with hcount == 0 && vcount == 0
//   err_pulse    out  1   pulse per cycle with a detected violation
//   err_flags    out  4   sticky: [0] h total, [1] h sync/blank, [2] v total,
//                         [3] v sync/blank
// -----------------------------------------------------------------------------
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int HOR_TOTAL    = HOR_TOTAL_TIME,
  parameter int HOR_BLANK    = HOR_BLANK_START,
  parameter int HOR_SYNC_ON  = HOR_SYNC_START,
  parameter int HOR_SYNC_OFF = HOR_SYNC_STOP,
  parameter int VER_TOTAL    = VER_TOTAL_TIME,
  parameter int VER_BLANK    = VER_BLANK_START,
  parameter int VER_SYNC_ON  = VER_SYNC_START,
  parameter int VER_SYNC_OFF = VER_SYNC_STOP,
  parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_hblnk,
  input  logic             in_vblnk,
  input  logic             clr_err,
  output logic             locked,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             line_start,
  output logic             frame_start,
  output logic             err_pulse,
  output logic [3:0]       err_flags
);

  // Edges are detected one cycle after the sample.
  // At that point the counters still hold the position of the previous
  // sample, so every expected edge position is compared as (position - 1).
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(HOR_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLANK_PRE = CNT_W'(HOR_BLANK - 1);
  localparam logic [CNT_W-1:0] H_SON_PRE   = CNT_W'(HOR_SYNC_ON - 1);
  localparam logic [CNT_W-1:0] H_SOFF_PRE  = CNT_W'(HOR_SYNC_OFF - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(VER_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_BLANK_PRE = CNT_W'(VER_BLANK - 1);
  localparam logic [CNT_W-1:0] V_SON_PRE   = CNT_W'(VER_SYNC_ON - 1);
  localparam logic [CNT_W-1:0] V_SOFF_PRE  = CNT_W'(VER_SYNC_OFF - 1);

  // A counter sitting here is about to hit CNT_MAX.
  // Flagging on this transition gives exactly one timeout error.
  localparam logic [CNT_W-1:0] CNT_NEAR    = CNT_MAX - CNT_W'(1);

  localparam logic [2:0]       LOCK_N      = 3'(LOCK_FRAMES);

  // ---------------------------------------------------------------------------
  // Input sampling and edge detection, one instance per sync input
  // ---------------------------------------------------------------------------
  logic [3:0] in_vec;
  logic [3:0] rise_vec;
  logic [3:0] fall_vec;

  assign in_vec[IDX_HSYNC] = in_hsync;
  assign in_vec[IDX_VSYNC] = in_vsync;
  assign in_vec[IDX_HBLNK] = in_hblnk;
  assign in_vec[IDX_VBLNK] = in_vblnk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
      vga_edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .din  (in_vec[gi]),
        .rise (rise_vec[gi]),
        .fall (fall_vec[gi])
      );
    end
  endgenerate

  logic line_anchor;
  logic frame_anchor;

  assign line_anchor  = fall_vec[IDX_HBLNK];
  assign frame_anchor = line_anchor & fall_vec[IDX_VBLNK];

  // ---------------------------------------------------------------------------
  // Recovered position counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hcount_reg, hcount_next;
  logic [CNT_W-1:0] vcount_reg, vcount_next;

  always_comb begin
    hcount_next = line_anchor ? '0 : sat_inc(hcount_reg);
    vcount_next = vcount_reg;
    if (frame_anchor) begin
      vcount_next = '0;
    end else if (line_anchor) begin
      vcount_next = sat_inc(vcount_reg);
    end
  end

  // ---------------------------------------------------------------------------
  // Timing checks (suppressed while searching)
  // ---------------------------------------------------------------------------
  sync_state_t state_reg, state_next;
  logic [2:0]  frame_cnt_reg, frame_cnt_next;
  err_flags_t  err_now;
  logic [3:0]  err_vec;
  logic        err_any;

  always_comb begin
    err_now = '0;

    err_now.h_total = (line_anchor && (hcount_reg != H_LAST)) ||
                      (!line_anchor && (hcount_reg == CNT_NEAR));

    err_now.h_sync  = (rise_vec[IDX_HBLNK] && (hcount_reg != H_BLANK_PRE)) ||
                      (rise_vec[IDX_HSYNC] && (hcount_reg != H_SON_PRE))   ||
                      (fall_vec[IDX_HSYNC] && (hcount_reg != H_SOFF_PRE));

    err_now.v_total = (frame_anchor && (vcount_reg != V_LAST))    ||
                      (fall_vec[IDX_VBLNK] && !line_anchor)       ||
                      (line_anchor && !frame_anchor && (vcount_reg == CNT_NEAR));

    // Vertical edges must land on a line anchor and at the right line.
    // The vcount used here is the value before this anchor's increment.
    err_now.v_sync  = (rise_vec[IDX_VBLNK] &&
                       (!line_anchor || (vcount_reg != V_BLANK_PRE))) ||
                      (rise_vec[IDX_VSYNC] &&
                       (!line_anchor || (vcount_reg != V_SON_PRE)))   ||
                      (fall_vec[IDX_VSYNC] &&
                       (!line_anchor || (vcount_reg != V_SOFF_PRE)));

    if (state_reg == SEARCH) begin
      err_now = '0;
    end
  end

  assign err_vec = err_now;
  assign err_any = |err_vec;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SEARCH;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      SEARCH: begin
        // The first frame anchor only aligns the counters.
        // Clean frames are counted from there on.
        if (frame_anchor) begin
          state_next     = ACQUIRE;
          frame_cnt_next = '0;
        end
      end
      ACQUIRE: begin
        if (err_any) begin
          state_next     = SEARCH;
          frame_cnt_next = '0;
        end else if (frame_anchor) begin
          if ((frame_cnt_reg + 3'd1) >= LOCK_N) begin
            state_next     = LOCKED;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 3'd1;
          end
        end
      end
      LOCKED: begin
        if (err_any) begin
          state_next     = SEARCH;
          frame_cnt_next = '0;
        end
      end
      default: begin
        state_next     = SEARCH;
        frame_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic       locked_reg;
  logic       line_start_reg;
  logic       frame_start_reg;
  logic       err_pulse_reg;
  logic [3:0] err_flags_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      locked_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      err_pulse_reg   <= 1'b0;
      err_flags_reg   <= '0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      locked_reg      <= (state_next == LOCKED);
      line_start_reg  <= line_anchor;
      frame_start_reg <= frame_anchor;
      err_pulse_reg   <= err_any;
      // Clear first, then OR in new errors.
      // A violation in the clearing cycle therefore survives.
      err_flags_reg   <= (clr_err ? 4'b0000 : err_flags_reg) | err_vec;
    end
  end

  assign locked      = locked_reg;
  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_flags   = err_flags_reg;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Directed bench for vga_sync_decoder.
// It uses a reduced timing mode (40 x 20) so that several frames fit in a short run.
// A behavioural generator drives the sync stream.
// Per-scenario knobs inject faults: stretched line, late hsync, early vsync,
// frozen inputs, and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT    = 40;
  localparam int HB    = 30;
  localparam int HSON  = 32;
  localparam int HSOFF = 36;
  localparam int VT    = 20;
  localparam int VB    = 15;
  localparam int VSON  = 16;
  localparam int VSOFF = 18;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_hsync, in_vsync, in_hblnk, in_vblnk, clr_err;
  logic        locked, line_start, frame_start, err_pulse;
  logic [10:0] hcount, vcount;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .HOR_TOTAL    (HT),
    .HOR_BLANK    (HB),
    .HOR_SYNC_ON  (HSON),
    .HOR_SYNC_OFF (HSOFF),
    .VER_TOTAL    (VT),
    .VER_BLANK    (VB),
    .VER_SYNC_ON  (VSON),
    .VER_SYNC_OFF (VSOFF),
    .LOCK_FRAMES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_hblnk    (in_hblnk),
    .in_vblnk    (in_vblnk),
    .clr_err     (clr_err),
    .locked      (locked),
    .hcount      (hcount),
    .vcount      (vcount),
    .line_start  (line_start),
    .frame_start (frame_start),
    .err_pulse   (err_pulse),
    .err_flags   (err_flags)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Generator state and fault knobs
  int gh = 0, gv = 0, line_len = HT, hs_shift = 0;
  bit vs_early = 1'b0, freeze = 1'b0;
  int last_h = 0, last_v = 0, exp_h = 0, exp_v = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Present one generator sample, wait for the clock, then advance the generator.
  // After the call, exp_h/exp_v hold the position presented in the previous
  // call. That is what the decoder should show now.
  task automatic tick();
    if (freeze) begin
      in_hblnk = 1'b0;
      in_hsync = 1'b0;
      in_vblnk = 1'b0;
      in_vsync = 1'b0;
    end else begin
      in_hblnk = (gh >= HB);
      in_hsync = (gh >= HSON + hs_shift) && (gh < HSOFF);
      in_vblnk = (gv >= VB);
      in_vsync = ((gv >= VSON) && (gv < VSOFF)) ||
                 (vs_early && (gv == VSON - 1) && (gh >= 20));
    end
    @(posedge clk);
    #1;
    exp_h  = last_h;
    exp_v  = last_v;
    last_h = gh;
    last_v = gv;
    if (gh >= line_len - 1) begin
      gh       = 0;
      line_len = HT;
      hs_shift = 0;
      gv       = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  // Run the generator until (h, v) is the next sample to be presented.
  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v) && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  // Wait for lock. Lock must come with the 3rd frame_start, with no error pulses.
  task automatic wait_lock(input string tag);
    int fs = 0;
    int n = 0;
    int pulses = 0;
    while (!locked && n < 6 * FRAME) begin
      tick();
      n++;
      pulses += int'(err_pulse);
      if (frame_start) begin
        fs++;
        check({tag, "_fs_line_start"}, line_start, 1);
        check({tag, "_fs_hcount"}, hcount, 0);
        check({tag, "_fs_vcount"}, vcount, 0);
      end
    end
    check({tag, "_locked"}, locked, 1);
    check({tag, "_lock_frame"}, fs, 3);
    check({tag, "_lock_on_fs"}, frame_start, 1);
    check({tag, "_no_err"}, pulses, 0);
    $display("[TB] %s: lock after %0d cycles, %0d frame starts", tag, n, fs);
  endtask

  task automatic wait_err(input string tag, input int bound);
    int n = 0;
    while (!err_pulse && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_err_seen"}, err_pulse, 1);
    $display("[TB] %s: err_pulse after %0d cycles, flags=%b hcount=%0d vcount=%0d",
             tag, n, err_flags, hcount, vcount);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    clr_err  = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    in_hblnk = 1'b0;
    in_vblnk = 1'b0;

    // Reset state
    repeat (4) tick();
    check("rst_locked", locked, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_flags", err_flags, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    rst = 1'b0;

    // 1: clean stream locks; counters follow the generator 2 cycles late
    wait_lock("t1");
    check("t1_flags", err_flags, 0);
    repeat (HT) begin
      tick();
      check("t1_hcount", hcount, exp_h);
      check("t1_vcount", vcount, exp_v);
      check("t1_line_start", line_start, (exp_h == 0));
    end
    pulses = 0;
    repeat (FRAME) begin
      tick();
      pulses += int'(err_pulse);
    end
    check("t1_frame_no_err", pulses, 0);
    check("t1_frame_flags", err_flags, 0);
    check("t1_still_locked", locked, 1);

    // 2: one line of HT+1 cycles
    goto(0, 5);
    line_len = HT + 1;
    wait_err("t2", 3 * HT);
    check("t2_flags", err_flags, 4'b0001);
    check("t2_locked", locked, 0);
    check("t2_err_hcount", hcount, 0);
    tick();
    check("t2_pulse_width", err_pulse, 0);
    check("t2_flags_sticky", err_flags, 4'b0001);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_clr", err_flags, 0);
    wait_lock("t2_relock");

    // 3: hsync rise one cycle late on one line
    goto(0, 7);
    hs_shift = 1;
    wait_err("t3", 3 * HT);
    check("t3_flags", err_flags, 4'b0010);
    check("t3_locked", locked, 0);
    check("t3_err_hcount", hcount, HSON + 1);
    check("t3_err_vcount", vcount, 7);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    wait_lock("t3_relock");

    // 4: vsync rises mid-line, then clr_err
    goto(0, VB);
    vs_early = 1'b1;
    wait_err("t4", 2 * HT);
    vs_early = 1'b0;
    check("t4_flags", err_flags, 4'b1000);
    check("t4_err_hcount", hcount, 20);
    check("t4_err_vcount", vcount, VB);
    check("t4_locked", locked, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_clr", err_flags, 0);
    wait_lock("t4_relock");

    // 5: inputs frozen in active video -> hcount timeout.
    // clr_err is held high throughout, so the new flag must beat the clear.
    goto(5, 2);
    freeze  = 1'b1;
    clr_err = 1'b1;
    wait_err("t5", 2200);
    check("t5_flags", err_flags, 4'b0001);
    check("t5_hcount_sat", hcount, 2047);
    check("t5_vcount", vcount, 2);
    check("t5_locked", locked, 0);
    pulses = 0;
    repeat (50) begin
      tick();
      pulses += int'(err_pulse);
    end
    check("t5_no_wrap", hcount, 2047);
    check("t5_single_err", pulses, 0);
    check("t5_flags_cleared", err_flags, 0);
    clr_err = 1'b0;
    freeze  = 1'b0;
    wait_lock("t5_relock");

    // 6: reset mid-frame, then a clean relock with no errors
    goto(17, 10);
    rst = 1'b1;
    tick();
    check("t6_locked", locked, 0);
    check("t6_hcount", hcount, 0);
    check("t6_vcount", vcount, 0);
    check("t6_flags", err_flags, 0);
    check("t6_pulse", err_pulse, 0);
    check("t6_line_start", line_start, 0);
    check("t6_frame_start", frame_start, 0);
    rst = 1'b0;
    wait_lock("t6_relock");
    check("t6_flags_after", err_flags, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
